// File: rtl/cpu_controller_pkg.sv
// Shared opcode/phase encodings and decode helpers for the 8-bit RISC CPU
// control path; the ALU and instruction decoder reuse these definitions.
package cpu_controller_pkg;

  localparam int PHASE_W = 3;
  localparam int OP_W    = 3;

  localparam logic [OP_W-1:0] OP_HLT = 3'b000;
  localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_LDA = 3'b101;
  localparam logic [OP_W-1:0] OP_STO = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP = 3'b111;

  localparam logic [PHASE_W-1:0] PH_INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] PH_INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] PH_INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] PH_IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] PH_OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] PH_OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] PH_ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] PH_STORE      = 3'd7;

  // Full set of strobes produced by the sequencer in one cycle.
  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic data_e;
    logic load_pc;
    logic inc_pc;
  } ctrl_t;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Instruction-cycle phase counter: wraps after the last phase, holds when
// enable is low or freeze is high; asynchronous active-low reset to phase 0.
module cpu_phase_counter
  import cpu_controller_pkg::*;
#(
  parameter int NUM_PHASES = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               freeze,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (enable && !freeze) begin
      if (phase_q == LAST_PHASE) phase_d = '0;
      else                       phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: decodes phase/opcode/zero into PC and datapath strobes
// with zero latency; enable low holds the phase and masks write-type strobes.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int NUM_PHASES = 8,
  parameter int OPCODE_W   = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                wr,
  output logic                ld_ir,
  output logic                ld_ac,
  output logic                data_e,
  output logic                load_pc,
  output logic                inc_pc,
  output logic                halt,
  output logic [PHASE_W-1:0]  phase
);

  logic  halted_q;
  logic  hlt_decode;
  logic  alu_op;
  ctrl_t dec;
  ctrl_t ctrl;

  cpu_phase_counter #(
    .NUM_PHASES (NUM_PHASES)
  ) u_phase_counter (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .freeze (halted_q),
    .phase  (phase)
  );

  assign alu_op     = is_aluop(Opcode);
  assign hlt_decode = (phase == PH_OP_ADDR) && (Opcode == OP_HLT);

  // Raw phase decode, before halt and enable masking.
  always_comb begin
    dec = '0;
    unique case (phase)
      PH_INST_ADDR: begin
        dec.sel = 1'b1;
      end
      PH_INST_FETCH: begin
        dec.sel = 1'b1;
        dec.rd  = 1'b1;
      end
      PH_INST_LOAD: begin
        dec.sel   = 1'b1;
        dec.rd    = 1'b1;
        dec.ld_ir = 1'b1;
      end
      PH_IDLE: begin
        dec.sel = 1'b1;
        dec.rd  = 1'b1;
      end
      PH_OP_ADDR: begin
        dec.inc_pc = 1'b1;
      end
      PH_OP_FETCH: begin
        dec.rd = alu_op;
      end
      PH_ALU_OP: begin
        dec.rd      = alu_op;
        dec.inc_pc  = (Opcode == OP_SKZ) && zero;
        dec.load_pc = (Opcode == OP_JMP);
        dec.data_e  = (Opcode == OP_STO);
      end
      PH_STORE: begin
        dec.rd      = alu_op;
        dec.ld_ac   = alu_op;
        dec.load_pc = (Opcode == OP_JMP);
        dec.wr      = (Opcode == OP_STO);
        dec.data_e  = (Opcode == OP_STO);
      end
      default: dec = '0;
    endcase
  end

  // A frozen cycle must not repeat a state-changing strobe; reads and
  // bus drive are idempotent, so they keep their decode.
  always_comb begin
    ctrl = dec;
    if (!enable) begin
      ctrl.wr      = 1'b0;
      ctrl.ld_ir   = 1'b0;
      ctrl.ld_ac   = 1'b0;
      ctrl.load_pc = 1'b0;
      ctrl.inc_pc  = 1'b0;
    end
    if (halted_q) begin
      ctrl.rd      = 1'b0;
      ctrl.wr      = 1'b0;
      ctrl.ld_ir   = 1'b0;
      ctrl.ld_ac   = 1'b0;
      ctrl.data_e  = 1'b0;
      ctrl.load_pc = 1'b0;
      ctrl.inc_pc  = 1'b0;
    end
  end

  // Halt latches on the edge that leaves OP_ADDR; the counter steps to
  // OP_FETCH on that same edge and then freezes there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     halted_q <= 1'b0;
    else if (enable && hlt_decode)  halted_q <= 1'b1;
  end

  assign sel     = ctrl.sel;
  assign rd      = ctrl.rd;
  assign wr      = ctrl.wr;
  assign ld_ir   = ctrl.ld_ir;
  assign ld_ac   = ctrl.ld_ac;
  assign data_e  = ctrl.data_e;
  assign load_pc = ctrl.load_pc;
  assign inc_pc  = ctrl.inc_pc;
  assign halt    = halted_q || hlt_decode;

  a_pc_strobes_exclusive: assert property (
    @(posedge clock) disable iff (!reset) !(load_pc && inc_pc)
  );

endmodule

// File: tb/tb_cpu_controller.sv
// Directed test-plan sequences followed by randomized cycles, every cycle
// checked against a phase/halt reference model of the instruction cycle.
module tb_cpu_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] Opcode = 3'd0;
  logic       zero = 1'b0;
  logic       sel, rd, wr, ld_ir, ld_ac, data_e, load_pc, inc_pc, halt;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_phase  = 0;
  bit m_halted = 1'b0;
  int halted_cycles = 0;

  cpu_controller dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .Opcode  (Opcode),
    .zero    (zero),
    .sel     (sel),
    .rd      (rd),
    .wr      (wr),
    .ld_ir   (ld_ir),
    .ld_ac   (ld_ac),
    .data_e  (data_e),
    .load_pc (load_pc),
    .inc_pc  (inc_pc),
    .halt    (halt),
    .phase   (phase)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s ph=%0d op=%0d en=%0d: got %0d want %0d", tag, m_phase, Opcode, enable, obs, exp);
    end
  endtask

  // Expected strobes derived from the instruction-cycle rules.
  task automatic check_all(input string ctx);
    bit alu, en, e_sel, e_rd, e_wr, e_ir, e_ac, e_de, e_ld, e_inc, e_halt;
    alu    = (Opcode >= 3'd2) && (Opcode <= 3'd5);
    en     = enable;
    e_sel  = (m_phase <= 3);
    e_halt = m_halted || (m_phase == 4 && Opcode == 3'd0);
    e_rd   = (m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && alu);
    e_ir   = en && m_phase == 2;
    e_inc  = en && (m_phase == 4 || (m_phase == 6 && Opcode == 3'd1 && zero));
    e_ld   = en && (m_phase == 6 || m_phase == 7) && Opcode == 3'd7;
    e_de   = (m_phase == 6 || m_phase == 7) && Opcode == 3'd6;
    e_wr   = en && m_phase == 7 && Opcode == 3'd6;
    e_ac   = en && m_phase == 7 && alu;
    if (m_halted) begin
      e_rd = 0; e_ir = 0; e_inc = 0; e_ld = 0; e_de = 0; e_wr = 0; e_ac = 0;
    end
    chk({ctx, ".phase"},   phase, 3'(m_phase));
    chk({ctx, ".sel"},     {2'b0, sel},     {2'b0, e_sel});
    chk({ctx, ".rd"},      {2'b0, rd},      {2'b0, e_rd});
    chk({ctx, ".wr"},      {2'b0, wr},      {2'b0, e_wr});
    chk({ctx, ".ld_ir"},   {2'b0, ld_ir},   {2'b0, e_ir});
    chk({ctx, ".ld_ac"},   {2'b0, ld_ac},   {2'b0, e_ac});
    chk({ctx, ".data_e"},  {2'b0, data_e},  {2'b0, e_de});
    chk({ctx, ".load_pc"}, {2'b0, load_pc}, {2'b0, e_ld});
    chk({ctx, ".inc_pc"},  {2'b0, inc_pc},  {2'b0, e_inc});
    chk({ctx, ".halt"},    {2'b0, halt},    {2'b0, e_halt});
    chk({ctx, ".pc_excl"}, {2'b0, load_pc && inc_pc}, 3'd0);
  endtask

  // One clock cycle: apply inputs after the falling edge, check, then advance model.
  task automatic cyc(input string ctx, input bit en, input logic [2:0] op, input bit z);
    enable = en;
    Opcode = op;
    zero   = z;
    #1;
    check_all(ctx);
    @(posedge clock);
    if (en && !m_halted) begin
      if (m_phase == 4 && op == 3'd0) m_halted = 1'b1;
      m_phase = (m_phase + 1) % 8;
    end
    @(negedge clock);
  endtask

  task automatic do_reset(input string ctx);
    reset = 1'b0;
    m_phase = 0;
    m_halted = 1'b0;
    #1;
    check_all(ctx);
    #9;
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    do_reset("reset");

    for (int i = 0; i < 8; i++) cyc("add", 1'b1, 3'd2, 1'b0);
    chk("add.wrap", phase, 3'd0);
    for (int i = 0; i < 8; i++) cyc("jmp", 1'b1, 3'd7, 1'b0);
    for (int i = 0; i < 8; i++) cyc("skz_z1", 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 8; i++) cyc("skz_z0", 1'b1, 3'd1, 1'b0);
    for (int i = 0; i < 8; i++) cyc("sto", 1'b1, 3'd6, 1'b0);

    // Freeze during INST_LOAD, then resume
    cyc("frz_pre", 1'b1, 3'd2, 1'b0);
    cyc("frz_pre", 1'b1, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) cyc("frozen", 1'b0, 3'd2, 1'b0);
    chk("frozen.phase", phase, 3'd2);
    for (int i = 0; i < 6; i++) cyc("resume", 1'b1, 3'd2, 1'b0);

    // Halt and stay halted for 20 cycles
    for (int i = 0; i < 5; i++) cyc("hlt_run", 1'b1, 3'd0, 1'b0);
    chk("hlt.flag", {2'b0, halt}, 3'd1);
    for (int i = 0; i < 20; i++) cyc("halted", 1'b1, 3'd0, 1'b0);
    chk("halted.phase", phase, 3'd5);
    do_reset("hlt_reset");
    chk("hlt_reset.halt", {2'b0, halt}, 3'd0);

    // Randomized run with occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] op;
      bit en, z;
      op = 3'($urandom_range(0, 7));
      if (op == 3'd0 && ($urandom % 4) != 0) op = 3'($urandom_range(1, 7));
      en = ($urandom % 5) != 0;
      z  = 1'($urandom % 2);
      if (m_halted) halted_cycles++;
      else          halted_cycles = 0;
      if (halted_cycles > 10 || ($urandom % 97) == 0) begin
        halted_cycles = 0;
        do_reset("rand_reset");
      end else begin
        cyc("rand", en, op, z);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
